// File: rtl/dram_dma_pkg.sv
// Shared widths, FSM state encoding and command modes for the DRAM DMA engine.
package dram_pkg;

    localparam int AW = 18;
    localparam int DW = 9;
    localparam int LW = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dram_dma_if.sv
// Command, CPU and DRAM port bundle between the DMA engine (slave) and its surroundings (master).
interface dram_dma_if;
    import dram_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_mode;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_fill;
    logic          busy;
    logic          done;

    logic          cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_stall;

    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill,
        input  cpu_write, cpu_addr, cpu_din,
        input  mem_dout,
        output cmd_ready, busy, done,
        output cpu_dout, cpu_stall,
        output mem_write, mem_addr, mem_din
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_fill,
        output cpu_write, cpu_addr, cpu_din,
        output mem_dout,
        input  cmd_ready, busy, done,
        input  cpu_dout, cpu_stall,
        input  mem_write, mem_addr, mem_din
    );

endinterface

// File: rtl/dram_dma.sv
// DMA engine owning the single-port data DRAM: CPU pass-through when idle,
// ascending block copy (read/write pairs) or block fill on command.
module dram_dma
    import dram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    dram_dma_if.slave  bus
);

    state_t        state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [LW-1:0] remaining;
    logic          mode;
    logic [DW-1:0] fill_word;
    logic [DW-1:0] rd_buf;
    logic          idle;

    assign idle = (state == IDLE);

    // Sequencer: command latch, pointer/down-counter updates and the copy data buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            mode      <= MODE_COPY;
            fill_word <= '0;
            rd_buf    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        src_ptr   <= bus.cmd_src;
                        dst_ptr   <= bus.cmd_dst;
                        remaining <= bus.cmd_len;
                        mode      <= bus.cmd_mode;
                        fill_word <= bus.cmd_fill;
                        if (bus.cmd_len == '0)
                            state <= DONE;
                        else if (bus.cmd_mode == MODE_FILL)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    rd_buf <= bus.mem_dout;
                    state  <= WR;
                end
                WR: begin
                    src_ptr   <= src_ptr + AW'(1);
                    dst_ptr   <= dst_ptr + AW'(1);
                    remaining <= remaining - LW'(1);
                    if (remaining == LW'(1))
                        state <= DONE;
                    else if (mode == MODE_COPY)
                        state <= RD;
                    else
                        state <= WR;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // DRAM port mux; every write path is gated by reset so nothing lands while rst_n is low.
    always_comb begin
        bus.mem_write = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_din   = bus.cpu_din;
        case (state)
            IDLE: begin
                bus.mem_write = bus.cpu_write & rst_n;
            end
            RD: begin
                bus.mem_addr = src_ptr;
            end
            WR: begin
                bus.mem_addr  = dst_ptr;
                bus.mem_write = rst_n;
                bus.mem_din   = (mode == MODE_FILL) ? fill_word : rd_buf;
            end
            default: begin
                bus.mem_write = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready = idle & rst_n;
    assign bus.cpu_stall = ~(idle & rst_n);
    assign bus.busy      = ~idle;
    assign bus.done      = (state == DONE);
    assign bus.cpu_dout  = bus.mem_dout;

endmodule

// File: tb/tb_dram_dma.sv
// Randomised scoreboard bench for dram_dma: behavioural DRAM plus a word-level reference memory.
module tb_dram_dma;
    import dram_pkg::*;

    localparam int MEM_WORDS = 1 << AW;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;

    dram_dma_if bus();

    dram_dma dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] dram    [0:MEM_WORDS-1];
    logic [DW-1:0] ref_mem [0:MEM_WORDS-1];

    assign bus.mem_dout = dram[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write)
            dram[bus.mem_addr] <= bus.mem_din;
    end

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  accept_cyc = 0;
    wr_t exp_wr[$];
    int  exp_lat[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every DRAM write and every done pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready)
            accept_cyc = cyc;
        if (bus.mem_write) begin
            if (exp_wr.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected write: got addr %0h data %0h, expected no write", bus.mem_addr, bus.mem_din);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                checkOutput("write addr", 32'(bus.mem_addr), 32'(e.a));
                checkOutput("write data", 32'(bus.mem_din), 32'(e.d));
            end
        end
        if (bus.done) begin
            if (exp_lat.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected done: got done=1, expected 0");
            end else begin
                checkOutput("done latency", 32'(cyc - accept_cyc), 32'(exp_lat.pop_front()));
            end
        end
    end

    task automatic cpuStore(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        bus.cpu_write = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_din   = d;
        ref_mem[a]    = d;
        exp_wr.push_back('{a, d});
        @(posedge clk); #1;
        bus.cpu_write = 1'b0;
    endtask

    task automatic cpuLoad(input logic [AW-1:0] a);
        @(posedge clk); #1;
        bus.cpu_addr = a;
        @(negedge clk);
        checkOutput("cpu load", 32'(bus.cpu_dout), 32'(ref_mem[a]));
        checkOutput("cpu stall idle", 32'(bus.cpu_stall), 32'd0);
    endtask

    // Issues one command (optionally with a same-edge CPU store) and waits for its done pulse.
    task automatic applyStimulus(input logic mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                 input logic [LW-1:0] len, input logic [DW-1:0] fill,
                                 input bit with_store, input logic [AW-1:0] s_addr, input logic [DW-1:0] s_data);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            stall_err;
        bit            got_done;
        @(posedge clk); #1;
        if (with_store) begin
            bus.cpu_write   = 1'b1;
            bus.cpu_addr    = s_addr;
            bus.cpu_din     = s_data;
            ref_mem[s_addr] = s_data;
            exp_wr.push_back('{s_addr, s_data});
        end
        for (int i = 0; i < int'(len); i++) begin
            a = dst + AW'(i);
            d = mode ? fill : ref_mem[src + AW'(i)];
            ref_mem[a] = d;
            exp_wr.push_back('{a, d});
        end
        if (len == '0)
            exp_lat.push_back(1);
        else if (mode == MODE_FILL)
            exp_lat.push_back(int'(len) + 1);
        else
            exp_lat.push_back(2 * int'(len) + 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_len   = len;
        bus.cmd_fill  = fill;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cpu_write = 1'b0;
        stall_err = 0;
        got_done  = 1'b0;
        for (int n = 0; n < 3 * int'(len) + 10; n++) begin
            @(negedge clk);
            if (!bus.cpu_stall || bus.cmd_ready || !bus.busy)
                stall_err++;
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
        end
        checkOutput("done seen", 32'(got_done), 32'd1);
        checkOutput("stall while busy", 32'(stall_err), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global timeout: simulation did not finish, expected $finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [DW-1:0] v;
        logic [AW-1:0] base;
        int            diffs;
        for (int i = 0; i < MEM_WORDS; i++) begin
            v = DW'($urandom);
            dram[i]    = v;
            ref_mem[i] = v;
        end
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = MODE_COPY;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        bus.cmd_fill  = '0;
        bus.cpu_write = 1'b1;
        bus.cpu_addr  = AW'(5);
        bus.cpu_din   = DW'(9'h155);

        // Reset state, with a CPU store held active that must not reach the DRAM.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset mem_write", 32'(bus.mem_write), 32'd0);
        checkOutput("reset cpu_stall", 32'(bus.cpu_stall), 32'd1);
        checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        bus.cpu_write = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle cmd_ready", 32'(bus.cmd_ready), 32'd1);

        cpuStore(AW'('h00010), DW'(9'h1A5));
        cpuLoad(AW'('h00010));

        applyStimulus(MODE_FILL, '0, AW'('h00100), LW'(4), DW'(9'h0FF), 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) cpuLoad(AW'('h00100 + i));

        cpuStore(AW'('h00200), DW'(1));
        cpuStore(AW'('h00201), DW'(2));
        cpuStore(AW'('h00202), DW'(3));
        applyStimulus(MODE_COPY, AW'('h00200), AW'('h00300), LW'(3), '0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) cpuLoad(AW'('h00300 + i));

        applyStimulus(MODE_FILL, '0, AW'('h3FFFE), LW'(3), DW'(9'h0A3), 1'b0, '0, '0);
        cpuLoad(AW'('h3FFFE));
        cpuLoad(AW'('h3FFFF));
        cpuLoad(AW'('h00000));

        cpuStore(AW'('h00400), DW'(7));
        applyStimulus(MODE_COPY, AW'('h00400), AW'('h00401), LW'(3), '0, 1'b0, '0, '0);
        for (int i = 1; i < 4; i++) cpuLoad(AW'('h00400 + i));

        applyStimulus(MODE_COPY, AW'('h00500), AW'('h00600), LW'(0), '0, 1'b0, '0, '0);

        applyStimulus(MODE_COPY, AW'('h00700), AW'('h00710), LW'(4), '0, 1'b1, AW'('h00701), DW'(9'h13C));
        for (int i = 0; i < 4; i++) cpuLoad(AW'('h00710 + i));

        for (int k = 0; k < 20; k++) begin
            base = ($urandom_range(0, 1) == 1) ? AW'('h3FFF0) : AW'('h00800);
            applyStimulus(logic'($urandom_range(0, 1)),
                          base + AW'($urandom_range(0, 31)),
                          base + AW'($urandom_range(0, 31)),
                          LW'($urandom_range(0, 12)),
                          DW'($urandom),
                          1'b0, '0, '0);
            cpuLoad(base + AW'($urandom_range(0, 40)));
        end

        // Reset during an 8-word copy, right after its second destination write.
        for (int i = 0; i < 2; i++) begin
            ref_mem[AW'('h00A00 + i)] = ref_mem[AW'('h00900 + i)];
            exp_wr.push_back('{AW'('h00A00 + i), ref_mem[AW'('h00900 + i)]});
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = MODE_COPY;
        bus.cmd_src   = AW'('h00900);
        bus.cmd_dst   = AW'('h00A00);
        bus.cmd_len   = LW'(8);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("post-reset busy", 32'(bus.busy), 32'd0);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 8; i++) cpuLoad(AW'('h00A00 + i));

        applyStimulus(MODE_FILL, '0, AW'('h00B00), LW'(2), DW'(9'h011), 1'b0, '0, '0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("pending writes", 32'(exp_wr.size()), 32'd0);
        checkOutput("pending done", 32'(exp_lat.size()), 32'd0);
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (dram[i] !== ref_mem[i]) diffs++;
        checkOutput("memory image diffs", 32'(diffs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dram_dma.md
# dram_dma

Single-initiator DMA and port-sharing engine that drives the processor's 9-bit-wide, 2^18-word single-port data DRAM. While idle it passes the CPU's load/store port straight through to the DRAM. On command it takes ownership of the DRAM port to perform a block copy or a block fill, stalling the CPU until it finishes.

## Interface
- AW, 18, DRAM address width in bits.
- DW, 9, DRAM word width in bits.
- LW, 18, transfer-length width in words.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset; one clock, no asynchronous reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command.
- cmd_mode  in  1  0 = copy, 1 = fill.
- cmd_src  in  AW  copy source start address.
- cmd_dst  in  AW  destination start address.
- cmd_len  in  LW  number of words to transfer.
- cmd_fill  in  DW  fill word.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- cpu_write  in  1  CPU store strobe.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU store data.
- cpu_dout  out  DW  CPU load data; always equals mem_dout.
- cpu_stall  out  1  CPU access is blocked this cycle.
- mem_write  out  1  DRAM write enable; the DRAM writes on the rising edge.
- mem_addr  out  AW  DRAM address.
- mem_din  out  DW  DRAM write data.
- mem_dout  in  DW  DRAM read data; combinational from mem_addr, valid in the same cycle.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - mem_write/mem_addr/mem_din = cpu_write/cpu_addr/cpu_din.
  - cpu_stall = 0, cmd_ready = 1.
- Command acceptance: the command is accepted on a cmd_valid & cmd_ready edge. On that edge the engine latches src_ptr, dst_ptr, remaining = cmd_len, mode and fill.
  - Copy with len ≠ 0 goes to RD.
  - Fill with len ≠ 0 goes to WR.
  - len = 0 goes to DONE. No memory access is made.
- RD (copy only):
  - mem_addr = src_ptr, mem_write = 0.
  - buf <= mem_dout at the edge; go to WR.
- WR:
  - mem_addr = dst_ptr, mem_write = 1.
  - mem_din = buf for copy, fill for fill.
  - At the edge: src_ptr++ and dst_ptr++ (modulo 2^AW, wraps 0x3FFFF→0x00000), remaining--.
  - If remaining was 1, go to DONE. Otherwise go to RD (copy) or stay in WR (fill).
- DONE: done = 1, cmd_ready = 0, cpu_stall = 1; go to IDLE.
- Outside IDLE:
  - cpu_stall = 1, cmd_ready = 0.
  - CPU inputs are ignored; a CPU store issued here is not performed. The CPU must hold the store until cpu_stall = 0.
- Copy is strictly ascending, one word at a time. With overlapping regions where dst > src, source data is replicated. This is defined behaviour and is not corrected.
- Same cycle cmd_valid and cpu_write in IDLE: the CPU store completes on that edge and the command is accepted on the same edge.
- Length arithmetic is unsigned LW-bit. cmd_len = 2^18 − 1 is the maximum.

## Timing
- Reset values: state IDLE, busy 0, done 0, mem_write 0 (CPU pass-through gated off), cpu_stall 1, cmd_ready 0.
- While rst_n = 0, mem_write is forced to 0.
- Reset mid-transfer: the next edge returns to IDLE. Words already written stay written. No done pulse.
- busy = 1 in RD, WR and DONE.
- done rises in the cycle after the final WR edge.
- Cycle counts, from the acceptance edge to the done cycle:
  - Copy of N words: 2N cycles in RD/WR, then 1 DONE cycle.
  - Fill of N words: N cycles, then 1 DONE cycle.
  - len = 0: 1 DONE cycle.
- The next command can be accepted one cycle after done, in IDLE.
- The DRAM read is combinational, so there are no read wait states. buf is the only data register.

## Structure
- Package dram_pkg holds:
  - AW, DW, LW
  - the state enum {IDLE, RD, WR, DONE}
  - MODE_COPY = 0 and MODE_FILL = 1
- No sub-module. The port mux is inline combinational logic selected by state == IDLE.
- The FSM, pointer registers and down-counter are in one always block.

## Test plan
- Pass-through: in IDLE, store 9'h1A5 at 0x00010 and then load 0x00010 → cpu_dout = 9'h1A5, cpu_stall = 0 throughout.
- Fill: dst = 0x00100, len = 4, fill = 9'h0FF → four consecutive WR cycles to 0x100–0x103, done on cycle 5 after acceptance, memory reads back 9'h0FF.
- Copy: preload 0x00200–0x00202 with 1, 2, 3; copy src = 0x200, dst = 0x300, len = 3 → 0x300–0x302 = 1, 2, 3, done on cycle 7, cpu_stall = 1 until done.
- Wrap and overlap:
  - Fill dst = 0x3FFFE, len = 3 → writes land at 0x3FFFE, 0x3FFFF, 0x00000.
  - Copy src = 0x400 (= 7), dst = 0x401, len = 3 → 0x401–0x403 all = 7.
- len = 0: done on the first cycle after acceptance, mem_write never asserted.
- Reset mid-copy: after 2 words of an 8-word copy, pulse rst_n low for 1 cycle → IDLE, no done, only the first 2 destination words changed, cmd_ready = 1 on the cycle after release.
